// File: rtl/pbuf2ddr_pkg.sv
// pbuf2ddr shared constants
// Word geometry, pbuf read latency and egress FIFO sizing.
package pbuf2ddr_pkg;

    localparam int DATA_W         = 16;
    localparam int BATCH          = 4;
    localparam int DDR_W          = DATA_W * BATCH;
    localparam int RD_LAT_DEF     = 2;
    localparam int FIFO_SLACK     = 2;
    localparam int FIFO_DEPTH_DEF = RD_LAT_DEF + FIFO_SLACK;

    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO
// Head word comes straight from the storage flops.
module sync_fifo
    import pbuf2ddr_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic [CW-1:0] w_count_nxt;
    logic          w_we;
    logic          w_re;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Accept a write when there is room or the head leaves this cycle
    always_comb begin
        w_we        = i_push && (!r_full || i_pop);
        w_re        = i_pop && !r_empty;
        w_count_nxt = r_count;
        if (w_we && !w_re) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_we && w_re) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage, pointers and registered occupancy flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_we) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_re) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/pbuf2ddr.sv
// pbuf2ddr: drains one PE parameter buffer onto the DDR write stream.
// Reads are credit-limited so the egress FIFO can always absorb returns.
module pbuf2ddr
    import pbuf2ddr_pkg::*;
#(
    parameter int BUF_DEPTH  = 256,
    parameter int ADDR_W     = bw(BUF_DEPTH),
    parameter int PE_NUM     = 32,
    parameter int PE_W       = bw(PE_NUM),
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    input  logic [7:0]              conf_trans_num,
    input  logic [ADDR_W-1:0]       conf_base_addr,
    input  logic [PE_W-1:0]         conf_pe_idx,
    output logic [ADDR_W-1:0]       pbuf_rd_addr,
    output logic [PE_NUM-1:0]       pbuf_rd_en,
    input  logic [PE_NUM*DDR_W-1:0] pbuf_rd_data,
    output logic [DDR_W-1:0]        ddr_data,
    output logic                    ddr_valid,
    output logic                    ddr_last,
    input  logic                    ddr_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t              r_state;
    logic [7:0]          r_trans;
    logic [7:0]          r_rd_cnt;
    logic [7:0]          r_tx_cnt;
    logic [PE_W-1:0]     r_pe;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [PE_NUM-1:0]   r_rd_en;
    logic                r_done;
    logic [RD_LAT-1:0]   r_ret_sr;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [DDR_W-1:0]    w_push_data;
    logic [DDR_W-1:0]    w_head;
    logic [SW-1:0]       w_inflight;
    logic [SW-1:0]       w_used;
    logic                w_credit;

    // Count reads on the pbuf bus or in its latency pipe
    always_comb begin
        w_inflight = SW'(|r_rd_en);
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + SW'(r_ret_sr[i]);
        end
    end

    assign w_pop       = !w_empty && ddr_ready;
    assign w_push      = r_ret_sr[RD_LAT-1] && (!w_full || w_pop);
    assign w_push_data = pbuf_rd_data[int'(r_pe)*DDR_W +: DDR_W];
    assign w_used      = w_inflight + SW'(w_count) - SW'(w_pop);
    assign w_credit    = (w_used < SW'(FIFO_DEPTH));

    // Track which cycles carry returning pbuf data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ret_sr <= '0;
        end else begin
            r_ret_sr[0] <= |r_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                r_ret_sr[i] <= r_ret_sr[i-1];
            end
        end
    end

    // Control FSM: launch, credit-gated read issue, drain to last beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_trans   <= '0;
            r_rd_cnt  <= '0;
            r_tx_cnt  <= '0;
            r_pe      <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= '0;
            r_done    <= 1'b1;
        end else begin
            if (w_pop) begin
                r_tx_cnt <= r_tx_cnt + 8'd1;
            end
            unique case (r_state)
                IDLE: begin
                    r_rd_en <= '0;
                    if (start) begin
                        r_trans              <= conf_trans_num;
                        r_pe                 <= conf_pe_idx;
                        r_rd_cnt             <= '0;
                        r_tx_cnt             <= '0;
                        r_done               <= 1'b0;
                        r_rd_addr            <= conf_base_addr;
                        r_rd_en[conf_pe_idx] <= 1'b1;
                        r_state <= (conf_trans_num == 8'd0) ? DRAIN : READ;
                    end
                end
                READ: begin
                    r_rd_en <= '0;
                    if (w_credit) begin
                        r_rd_en[r_pe] <= 1'b1;
                        r_rd_addr     <= r_rd_addr + ADDR_W'(1);
                        r_rd_cnt      <= r_rd_cnt + 8'd1;
                        if (r_rd_cnt + 8'd1 == r_trans) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_rd_en <= '0;
                    if (w_pop && (r_tx_cnt == r_trans)) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rd_en <= '0;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    sync_fifo #(
        .DW    (DDR_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign done         = r_done;
    assign pbuf_rd_addr = r_rd_addr;
    assign pbuf_rd_en   = r_rd_en;
    assign ddr_data     = w_head;
    assign ddr_valid    = !w_empty;
    assign ddr_last     = !w_empty && (r_tx_cnt == r_trans);

endmodule
